// File: rtl/no_akt_gen.sv
// -----------------------------------------------------------------------------
// no_akt_gen
// Gene-regulatory-network node holding its state in two copies:
//   - s0 (slow copy) applies pdk1_s0_i once every SLOW_DIV accepted start_s0_i
//   - s1 (fast copy) applies pdk1_s1_i on every accepted start_s1_i
// Also counts applied updates (saturating), flags when the copies agree
// (match_o, one cycle after the equalising update) and latches the fast-copy
// update count at the first match (found_o / match_step_o).
//
// Ports:
//   clk_i          clock, all logic on rising edge
//   rst_i          synchronous active-high reset
//   reset_nos_i    node re-initialisation strobe (loads init_state_i)
//   init_state_i   value loaded into both copies by reset_nos_i
//   start_s0_i     slow-copy update strobe
//   start_s1_i     fast-copy update strobe
//   hold_i         freeze; update strobes ignored while high
//   pdk1_s0_i      next-state value for s0
//   pdk1_s1_i      next-state value for s1
//   s0_o, s1_o     registered state copies
//   akt_s0_o/_s1_o same values as s0_o/s1_o
//   cnt_s0_o/_s1_o applied-update counters, saturating
//   match_o        registered: copies equal and armed
//   found_o        sticky first-match flag
//   match_step_o   cnt_s1 value captured at the first match
// -----------------------------------------------------------------------------
module no_akt_gen #(
    parameter int unsigned WIDTH    = 1,
    parameter int unsigned SLOW_DIV = 2,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             reset_nos_i,
    input  logic [WIDTH-1:0] init_state_i,
    input  logic             start_s0_i,
    input  logic             start_s1_i,
    input  logic             hold_i,
    input  logic [WIDTH-1:0] pdk1_s0_i,
    input  logic [WIDTH-1:0] pdk1_s1_i,
    output logic [WIDTH-1:0] s0_o,
    output logic [WIDTH-1:0] s1_o,
    output logic [WIDTH-1:0] akt_s0_o,
    output logic [WIDTH-1:0] akt_s1_o,
    output logic [CNT_W-1:0] cnt_s0_o,
    output logic [CNT_W-1:0] cnt_s1_o,
    output logic             match_o,
    output logic             found_o,
    output logic [CNT_W-1:0] match_step_o
);

    // With SLOW_DIV=1 the phase register degenerates to a constant 0 that
    // always equals PH_LAST, so s0 applies on every strobe without a special case.
    localparam int unsigned     PH_W    = (SLOW_DIV > 1) ? $clog2(SLOW_DIV) : 1;
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(SLOW_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [WIDTH-1:0] s0_q, s0_d;
    logic [WIDTH-1:0] s1_q, s1_d;
    logic [PH_W-1:0]  phase_q, phase_d;
    logic [CNT_W-1:0] cnt_s0_q, cnt_s0_d;
    logic [CNT_W-1:0] cnt_s1_q, cnt_s1_d;
    logic             armed_q, armed_d;
    logic             match_q, match_d;
    logic             found_q, found_d;
    logic [CNT_W-1:0] step_q, step_d;

    // Saturating increment: counters stick at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        logic [CNT_W-1:0] r;
        if (v == CNT_MAX) begin
            r = v;
        end else begin
            r = v + CNT_W'(1);
        end
        return r;
    endfunction

    // Next-state logic: re-init, match/first-match capture, gated update strobes.
    always_comb begin
        s0_d     = s0_q;
        s1_d     = s1_q;
        phase_d  = phase_q;
        cnt_s0_d = cnt_s0_q;
        cnt_s1_d = cnt_s1_q;
        armed_d  = armed_q;
        match_d  = match_q;
        found_d  = found_q;
        step_d   = step_q;

        if (reset_nos_i) begin
            // Phase preloaded so the first start_s0 after re-init applies.
            s0_d     = init_state_i;
            s1_d     = init_state_i;
            phase_d  = PH_LAST;
            cnt_s0_d = {CNT_W{1'b0}};
            cnt_s1_d = {CNT_W{1'b0}};
            armed_d  = 1'b0;
            match_d  = 1'b0;
            found_d  = 1'b0;
            step_d   = {CNT_W{1'b0}};
        end else begin
            // Match looks at the current copies, hence one cycle behind updates;
            // it keeps evaluating while hold is high.
            match_d = armed_q & (s0_q == s1_q);

            // First-match capture tracks the match transition itself so a match
            // that rises during hold is not lost.
            if (match_d && !found_q) begin
                found_d = 1'b1;
                step_d  = cnt_s1_q;
            end else begin
                found_d = found_q;
                step_d  = step_q;
            end

            if (!hold_i) begin
                if (start_s0_i) begin
                    if (phase_q == PH_LAST) begin
                        s0_d     = pdk1_s0_i;
                        phase_d  = {PH_W{1'b0}};
                        cnt_s0_d = sat_inc(cnt_s0_q);
                    end else begin
                        phase_d  = phase_q + PH_W'(1);
                    end
                end else begin
                    phase_d = phase_q;
                end

                if (start_s1_i) begin
                    s1_d     = pdk1_s1_i;
                    cnt_s1_d = sat_inc(cnt_s1_q);
                    armed_d  = 1'b1;
                end else begin
                    s1_d = s1_q;
                end
            end else begin
                phase_d = phase_q;
            end
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s0_q     <= {WIDTH{1'b0}};
            s1_q     <= {WIDTH{1'b0}};
            phase_q  <= {PH_W{1'b0}};
            cnt_s0_q <= {CNT_W{1'b0}};
            cnt_s1_q <= {CNT_W{1'b0}};
            armed_q  <= 1'b0;
            match_q  <= 1'b0;
            found_q  <= 1'b0;
            step_q   <= {CNT_W{1'b0}};
        end else begin
            s0_q     <= s0_d;
            s1_q     <= s1_d;
            phase_q  <= phase_d;
            cnt_s0_q <= cnt_s0_d;
            cnt_s1_q <= cnt_s1_d;
            armed_q  <= armed_d;
            match_q  <= match_d;
            found_q  <= found_d;
            step_q   <= step_d;
        end
    end

    assign s0_o         = s0_q;
    assign s1_o         = s1_q;
    assign akt_s0_o     = s0_q;
    assign akt_s1_o     = s1_q;
    assign cnt_s0_o     = cnt_s0_q;
    assign cnt_s1_o     = cnt_s1_q;
    assign match_o      = match_q;
    assign found_o      = found_q;
    assign match_step_o = step_q;

endmodule

// File: tb/tb_no_akt_gen.sv
// Bench for no_akt_gen: two instances (A: WIDTH=4 SLOW_DIV=2 CNT_W=16,
// B: WIDTH=4 SLOW_DIV=3 CNT_W=3) driven by the same inputs and compared
// against a pulse-counting reference model.
module tb_no_akt_gen;

    logic       clk = 1'b0;
    logic       rst, nos, st0, st1, hold;
    logic [3:0] init, p0, p1;

    logic [3:0]  a_s0, a_s1, a_k0, a_k1;
    logic [15:0] a_c0, a_c1, a_step;
    logic        a_match, a_found;
    logic [3:0]  b_s0, b_s1, b_k0, b_k1;
    logic [2:0]  b_c0, b_c1, b_step;
    logic        b_match, b_found;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    no_akt_gen #(.WIDTH(4), .SLOW_DIV(2), .CNT_W(16)) dut_a (
        .clk_i(clk), .rst_i(rst), .reset_nos_i(nos), .init_state_i(init),
        .start_s0_i(st0), .start_s1_i(st1), .hold_i(hold),
        .pdk1_s0_i(p0), .pdk1_s1_i(p1),
        .s0_o(a_s0), .s1_o(a_s1), .akt_s0_o(a_k0), .akt_s1_o(a_k1),
        .cnt_s0_o(a_c0), .cnt_s1_o(a_c1), .match_o(a_match),
        .found_o(a_found), .match_step_o(a_step));

    no_akt_gen #(.WIDTH(4), .SLOW_DIV(3), .CNT_W(3)) dut_b (
        .clk_i(clk), .rst_i(rst), .reset_nos_i(nos), .init_state_i(init),
        .start_s0_i(st0), .start_s1_i(st1), .hold_i(hold),
        .pdk1_s0_i(p0), .pdk1_s1_i(p1),
        .s0_o(b_s0), .s1_o(b_s1), .akt_s0_o(b_k0), .akt_s1_o(b_k1),
        .cnt_s0_o(b_c0), .cnt_s1_o(b_c1), .match_o(b_match),
        .found_o(b_found), .match_step_o(b_step));

    // Reference model, index 0 = instance A, 1 = instance B.
    // m_k counts accepted start_s0 pulses since the last reset; the slow copy
    // applies on pulse k when (k - m_base) is a multiple of the divider
    // (m_base=1 after re-init: pulses 1, 1+DIV, ...; m_base=0 after rst).
    int div  [2] = '{2, 3};
    int cmax [2] = '{65535, 7};
    int m_s0 [2], m_s1 [2], m_k [2], m_base [2], m_c0 [2], m_c1 [2], m_step [2];
    bit m_armed [2], m_match [2], m_found [2];

    task automatic model_edge();
        for (int i = 0; i < 2; i++) begin
            bit nm;
            nm = m_armed[i] && (m_s0[i] == m_s1[i]);
            if (rst || nos) begin
                m_s0[i] = rst ? 0 : int'(init);
                m_s1[i] = m_s0[i];
                m_k[i] = 0; m_base[i] = rst ? 0 : 1;
                m_c0[i] = 0; m_c1[i] = 0; m_step[i] = 0;
                m_armed[i] = 0; m_match[i] = 0; m_found[i] = 0;
            end else begin
                if (nm && !m_found[i]) begin
                    m_found[i] = 1;
                    m_step[i]  = m_c1[i];
                end
                m_match[i] = nm;
                if (!hold) begin
                    if (st0) begin
                        m_k[i]++;
                        if ((m_k[i] - m_base[i]) % div[i] == 0) begin
                            m_s0[i] = int'(p0);
                            if (m_c0[i] < cmax[i]) m_c0[i]++;
                        end
                    end
                    if (st1) begin
                        m_s1[i] = int'(p1);
                        if (m_c1[i] < cmax[i]) m_c1[i]++;
                        m_armed[i] = 1;
                    end
                end
            end
        end
    endtask

    task automatic idle();
        rst = 1'b0; nos = 1'b0; st0 = 1'b0; st1 = 1'b0; hold = 1'b0;
        init = 4'h0; p0 = 4'h0; p1 = 4'h0;
    endtask

    // One clock: DUT and model see the same inputs; outputs sampled #1 later.
    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic test_reset();
        idle();
        rst = 1'b1;
        cycle();
        cycle();
        rst = 1'b0;
        n_vec++;
        if ({a_s0, a_s1, a_k0, a_k1, a_c0, a_c1, a_match, a_found, a_step} !== 66'h0) begin
            n_err++;
            $display("FAIL reset_a got s0=%h s1=%h c0=%h c1=%h m=%b f=%b st=%h want all 0",
                     a_s0, a_s1, a_c0, a_c1, a_match, a_found, a_step);
        end
        n_vec++;
        if ({b_s0, b_s1, b_c0, b_c1, b_match, b_found, b_step} !== 19'h0) begin
            n_err++;
            $display("FAIL reset_b got s0=%h s1=%h c0=%h c1=%h m=%b f=%b want all 0",
                     b_s0, b_s1, b_c0, b_c1, b_match, b_found);
        end
    endtask

    task automatic test_cadence();
        logic [3:0] pv  [4] = '{4'hA, 4'hB, 4'hC, 4'hD};
        logic [3:0] e0  [4] = '{4'hA, 4'hA, 4'hC, 4'hC};
        idle();
        nos = 1'b1; init = 4'h3;
        cycle();
        idle();
        n_vec++;
        if (a_s0 !== 4'h3 || a_s1 !== 4'h3) begin
            n_err++;
            $display("FAIL cadence_init got s0=%h s1=%h want 3/3", a_s0, a_s1);
        end
        for (int i = 0; i < 4; i++) begin
            st0 = 1'b1; st1 = 1'b1; p0 = pv[i]; p1 = pv[i];
            cycle();
            n_vec++;
            if (a_s0 !== e0[i] || a_s1 !== pv[i] || a_k0 !== e0[i] || a_k1 !== pv[i]) begin
                n_err++;
                $display("FAIL cadence_step%0d got s0=%h s1=%h akt=%h/%h want s0=%h s1=%h",
                         i, a_s0, a_s1, a_k0, a_k1, e0[i], pv[i]);
            end
        end
        idle();
        n_vec++;
        if (a_c0 !== 16'd2 || a_c1 !== 16'd4) begin
            n_err++;
            $display("FAIL cadence_cnt got c0=%0d c1=%0d want 2/4", a_c0, a_c1);
        end
    endtask

    task automatic test_match();
        idle();
        nos = 1'b1; init = 4'h5;
        cycle();
        idle();
        st0 = 1'b1; st1 = 1'b1; p0 = 4'h7; p1 = 4'h7;
        cycle();
        idle();
        n_vec++;
        if (a_s0 !== 4'h7 || a_s1 !== 4'h7 || a_match !== 1'b0 || a_found !== 1'b0) begin
            n_err++;
            $display("FAIL match_edge_k got s0=%h s1=%h m=%b f=%b want 7/7/0/0",
                     a_s0, a_s1, a_match, a_found);
        end
        cycle();
        n_vec++;
        if (a_match !== 1'b1 || a_found !== 1'b1 || a_step !== 16'd1) begin
            n_err++;
            $display("FAIL match_edge_k1 got m=%b f=%b step=%0d want 1/1/1",
                     a_match, a_found, a_step);
        end
        st1 = 1'b1; p1 = 4'h2;
        cycle();
        idle();
        cycle();
        n_vec++;
        if (a_match !== 1'b0 || a_found !== 1'b1 || a_step !== 16'd1) begin
            n_err++;
            $display("FAIL match_drop got m=%b f=%b step=%0d want 0/1/1",
                     a_match, a_found, a_step);
        end
    endtask

    task automatic test_hold();
        idle();
        nos = 1'b1; init = 4'h3;
        cycle();
        idle();
        st0 = 1'b1; p0 = 4'h6;            // pulse 1 applies, phase back to 0
        cycle();
        hold = 1'b1; st0 = 1'b1; st1 = 1'b1; p0 = 4'h8; p1 = 4'h9;
        for (int i = 0; i < 3; i++) cycle();
        n_vec++;
        if (a_s0 !== 4'h6 || a_s1 !== 4'h3 || a_c0 !== 16'd1 || a_c1 !== 16'd0) begin
            n_err++;
            $display("FAIL hold_freeze got s0=%h s1=%h c0=%0d c1=%0d want 6/3/1/0",
                     a_s0, a_s1, a_c0, a_c1);
        end
        idle();
        st0 = 1'b1; p0 = 4'h8;            // phase untouched by hold: no apply
        cycle();
        n_vec++;
        if (a_s0 !== 4'h6 || a_c0 !== 16'd1) begin
            n_err++;
            $display("FAIL hold_phase1 got s0=%h c0=%0d want 6/1", a_s0, a_c0);
        end
        cycle();                          // next pulse applies
        n_vec++;
        if (a_s0 !== 4'h8 || a_c0 !== 16'd2) begin
            n_err++;
            $display("FAIL hold_phase2 got s0=%h c0=%0d want 8/2", a_s0, a_c0);
        end
        idle();
        hold = 1'b1; nos = 1'b1; init = 4'hE;
        cycle();
        idle();
        n_vec++;
        if (a_s0 !== 4'hE || a_s1 !== 4'hE || a_c0 !== 16'd0) begin
            n_err++;
            $display("FAIL hold_reinit got s0=%h s1=%h c0=%0d want E/E/0", a_s0, a_s1, a_c0);
        end
    endtask

    task automatic test_saturation();
        idle();
        nos = 1'b1; init = 4'h1;
        cycle();
        idle();
        for (int i = 1; i <= 10; i++) begin
            st1 = 1'b1; p1 = 4'(i);
            cycle();
            if (i == 6) begin
                n_vec++;
                if (b_c1 !== 3'd6) begin
                    n_err++;
                    $display("FAIL sat_pre got c1=%0d want 6", b_c1);
                end
            end
        end
        idle();
        n_vec++;
        if (b_c1 !== 3'd7 || a_c1 !== 16'd10) begin
            n_err++;
            $display("FAIL sat_stop got b_c1=%0d a_c1=%0d want 7/10", b_c1, a_c1);
        end
    endtask

    task automatic test_reinit();
        idle();
        st0 = 1'b1; st1 = 1'b1; p0 = 4'h2; p1 = 4'h4;
        cycle(); cycle(); cycle();
        nos = 1'b1; init = 4'h9; p0 = 4'hF; p1 = 4'hF;
        cycle();
        idle();
        n_vec++;
        if (a_s0 !== 4'h9 || a_s1 !== 4'h9 || a_c0 !== 16'd0 || a_c1 !== 16'd0 || a_found !== 1'b0) begin
            n_err++;
            $display("FAIL reinit got s0=%h s1=%h c0=%0d c1=%0d f=%b want 9/9/0/0/0",
                     a_s0, a_s1, a_c0, a_c1, a_found);
        end
        st0 = 1'b1; p0 = 4'h4;
        cycle();
        idle();
        n_vec++;
        if (a_s0 !== 4'h4 || a_c0 !== 16'd1 || b_s0 !== 4'h4 || b_c0 !== 3'd1) begin
            n_err++;
            $display("FAIL reinit_first got a_s0=%h a_c0=%0d b_s0=%h b_c0=%0d want 4/1/4/1",
                     a_s0, a_c0, b_s0, b_c0);
        end
    endtask

    task automatic test_random();
        logic [65:0] ea;
        logic [26:0] eb;
        for (int n = 0; n < 3000; n++) begin
            rst  = ($urandom_range(0, 199) == 0);
            nos  = ($urandom_range(0, 29) == 0);
            hold = ($urandom_range(0, 4) == 0);
            st0  = $urandom_range(0, 1) != 0;
            st1  = $urandom_range(0, 1) != 0;
            init = 4'($urandom_range(0, 15));
            p0   = 4'($urandom_range(0, 3));
            p1   = 4'($urandom_range(0, 3));
            cycle();
            ea = {4'(m_s0[0]), 4'(m_s1[0]), 4'(m_s0[0]), 4'(m_s1[0]),
                  16'(m_c0[0]), 16'(m_c1[0]), m_match[0], m_found[0], 16'(m_step[0])};
            eb = {4'(m_s0[1]), 4'(m_s1[1]), 4'(m_s0[1]), 4'(m_s1[1]),
                  3'(m_c0[1]), 3'(m_c1[1]), m_match[1], m_found[1], 3'(m_step[1])};
            n_vec++;
            if ({a_s0, a_s1, a_k0, a_k1, a_c0, a_c1, a_match, a_found, a_step} !== ea) begin
                n_err++;
                $display("FAIL random_a cycle %0d got %h want %h", n,
                         {a_s0, a_s1, a_k0, a_k1, a_c0, a_c1, a_match, a_found, a_step}, ea);
            end
            n_vec++;
            if ({b_s0, b_s1, b_k0, b_k1, b_c0, b_c1, b_match, b_found, b_step} !== eb) begin
                n_err++;
                $display("FAIL random_b cycle %0d got %h want %h", n,
                         {b_s0, b_s1, b_k0, b_k1, b_c0, b_c1, b_match, b_found, b_step}, eb);
            end
        end
        idle();
    endtask

    initial begin
        idle();
        test_reset();
        test_cadence();
        test_match();
        test_hold();
        test_saturation();
        test_reinit();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
